// File: rtl/enc8b10b_pkg.sv
// Shared constants and helpers for the multi-lane 8B/10B encoder.
package enc8b10b_pkg;

    localparam int unsigned SYM_W = 10;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam logic [4:0] K28 = 5'd28;
    localparam logic [4:0] K23 = 5'd23;
    localparam logic [4:0] K27 = 5'd27;
    localparam logic [4:0] K29 = 5'd29;
    localparam logic [4:0] K30 = 5'd30;
    localparam logic [2:0] Y7  = 3'd7;

    // Legal control characters: K28.0-K28.7 plus K23/27/29/30.7
    function automatic logic is_legal_k(input logic [7:0] b);
        return (b[4:0] == K28) ||
               ((b[7:5] == Y7) && ((b[4:0] == K23) || (b[4:0] == K27) ||
                                   (b[4:0] == K29) || (b[4:0] == K30)));
    endfunction

    // Data x values that need the alternate Dx.A7 to avoid a run of five
    function automatic logic use_alt7(input logic [4:0] x, input logic rd);
        if (rd == RD_NEG)
            return (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
        else
            return (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
    endfunction

endpackage

// File: rtl/enc8b10b_lane.sv
// Combinational single-lane 8B/10B encoder: 5b/6b then 3b/4b with RD threading.
module enc8b10b_lane
    import enc8b10b_pkg::*;
(
    input  logic [7:0]       byte_i,
    input  logic             k_i,
    input  logic             rd_i,
    output logic [SYM_W-1:0] sym_o,
    output logic             rd_o,
    output logic             kerr_o
);

    // RD- column of the 5b/6b table, written abcdei (a = MSB)
    function automatic logic [5:0] tbl6(input logic [4:0] x);
        case (x)
            5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
            5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
            5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
            5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
            5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
            5'd10: return 6'b010101;  5'd11: return 6'b110100;
            5'd12: return 6'b001101;  5'd13: return 6'b101100;
            5'd14: return 6'b011100;  5'd15: return 6'b010111;
            5'd16: return 6'b011011;  5'd17: return 6'b100011;
            5'd18: return 6'b010011;  5'd19: return 6'b110010;
            5'd20: return 6'b001011;  5'd21: return 6'b101010;
            5'd22: return 6'b011010;  5'd23: return 6'b111010;
            5'd24: return 6'b110011;  5'd25: return 6'b100110;
            5'd26: return 6'b010110;  5'd27: return 6'b110110;
            5'd28: return 6'b001110;  5'd29: return 6'b101110;
            5'd30: return 6'b011110;  default: return 6'b101011;
        endcase
    endfunction

    // RD- column of the 3b/4b table, written fghj (f = MSB)
    function automatic logic [3:0] tbl4(input logic [2:0] y, input logic alt);
        case (y)
            3'd0: return 4'b1011;  3'd1: return 4'b1001;
            3'd2: return 4'b0101;  3'd3: return 4'b1100;
            3'd4: return 4'b1101;  3'd5: return 4'b1010;
            3'd6: return 4'b0110;  default: return alt ? 4'b0111 : 4'b1110;
        endcase
    endfunction

    logic [4:0] x;
    logic [2:0] y;
    logic       k_ok, k28, unb6, unb4, rd6, alt7;
    logic [5:0] c6, code6;
    logic [3:0] c4, code4;
    logic [9:0] code10;

    assign x = byte_i[4:0];
    assign y = byte_i[7:5];

    always_comb begin
        k_ok   = k_i && is_legal_k(byte_i);
        kerr_o = k_i && !k_ok;
        k28    = k_ok && (x == K28);

        c6    = k28 ? 6'b001111 : tbl6(x);
        unb6  = ($countones(c6) != 3);
        code6 = ((rd_i == RD_POS) && (unb6 || (x == 5'd7))) ? ~c6 : c6;
        rd6   = rd_i ^ unb6;

        alt7  = (y == Y7) && (k_ok || use_alt7(x, rd6));
        c4    = tbl4(y, alt7);
        unb4  = ($countones(c4) != 2);
        code4 = ((rd6 == RD_POS) && (unb4 || (y == 3'd3))) ? ~c4 : c4;
        // Balanced K28 tails are inverted when the 6b code left RD negative
        if (k28 && (rd6 == RD_NEG) &&
            ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6)))
            code4 = ~code4;
        rd_o = rd6 ^ unb4;

        code10 = {code6, code4};
        sym_o  = '0;
        for (int unsigned b = 0; b < SYM_W; b++)
            sym_o[b] = code10[SYM_W-1-b];
    end

endmodule

// File: rtl/encoder_8b10b_nlane.sv
// Registered LANES-wide 8B/10B encoder with lane-to-lane RD chaining and valid/ready.
module encoder_8b10b_nlane
    import enc8b10b_pkg::*;
#(
    parameter int unsigned LANES = 4
)
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [8*LANES-1:0]    i_data,
    input  logic [LANES-1:0]      i_datak,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_rd_load,
    input  logic                  i_rd_val,
    output logic [10*LANES-1:0]   o_data,
    output logic [LANES-1:0]      o_kerr,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_run_disp
);

    logic [SYM_W*LANES-1:0] data_d, data_q, enc_data;
    logic [LANES-1:0]       kerr_d, kerr_q, enc_kerr;
    logic                   valid_d, valid_q, rd_d, rd_q;
    logic [LANES:0]         rd_chain;
    logic                   accept;

    assign o_ready     = !valid_q || i_ready;
    assign accept      = i_valid && o_ready;
    assign rd_chain[0] = i_rd_load ? i_rd_val : rd_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        enc8b10b_lane u_lane (
            .byte_i (i_data[8*g +: 8]),
            .k_i    (i_datak[g]),
            .rd_i   (rd_chain[g]),
            .sym_o  (enc_data[SYM_W*g +: SYM_W]),
            .rd_o   (rd_chain[g+1]),
            .kerr_o (enc_kerr[g])
        );
    end

    // Without an accepted beat the stored RD only moves on an explicit load
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        kerr_d  = kerr_q;
        rd_d    = rd_chain[0];
        if (accept) begin
            valid_d = 1'b1;
            data_d  = enc_data;
            kerr_d  = enc_kerr;
            rd_d    = rd_chain[LANES];
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            kerr_q  <= '0;
            rd_q    <= RD_NEG;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            kerr_q  <= kerr_d;
            rd_q    <= rd_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_kerr     = kerr_q;
    assign o_run_disp = rd_q;

endmodule
